// File: rtl/wb_uart_loader.sv
// rtl/wb_uart_loader.sv - UART-to-Wishbone boot loader with ACK/NAK response
//
// Purpose:
//   Receives framed bytes on RX (8N1, CLK_DIV clocks per bit) and writes the
//   payload words to a Wishbone bus. Frame layout:
//     0xA5 | base address (4 bytes LE) | word count N (2 bytes LE) | N words (4 bytes LE each)
//   After the frame completes, one response byte is sent on TX:
//     0x06 if every write was acked, or 0x15 if the frame was aborted by a bus error or an overrun.
//
// Ports:
//   clk_i         single rising-edge clock
//   reset_i       asynchronous active-high reset
//   RX / TX       UART receive / transmit lines (idle high)
//   master_dat_o  Wishbone write data
//   master_dat_i  Wishbone read data (ignored)
//   adr_o         Wishbone word address
//   cyc_o, stb_o, we_o, sel_o  Wishbone master controls
//   ack_i, err_i  Wishbone slave responses
//   busy_o        high from a valid sync byte until the response byte has been sent
//   done_o        one-cycle pulse at the end of the response stop bit
module wb_uart_loader #(
  parameter int CLK_DIV = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            RX,
  output logic            TX,
  output logic [XLEN-1:0] master_dat_o,
  input  logic [XLEN-1:0] master_dat_i,
  output logic [XLEN-3:0] adr_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [3:0]      sel_o,
  input  logic            ack_i,
  input  logic            err_i,
  output logic            busy_o,
  output logic            done_o
);

  localparam int             CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {F_SYNC, F_ADDR, F_COUNT, F_DATA, F_RESP} frame_t;
  typedef enum logic {B_IDLE, B_WRITE} bus_t;

  // Read data is never used; fold it into a sink so it is not left dangling.
  logic w_unused;
  assign w_unused = ^master_dat_i;

  // ---------------- receiver ----------------
  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic          r_rx_active;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_idx;   // 0 = start bit, 1..8 = data, 9 = stop
  logic [7:0]    r_rx_shift;
  logic          r_rx_valid, r_rx_ferr;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_active <= 1'b0;
      r_rx_cnt    <= '0;
      r_rx_idx    <= 4'd0;
      r_rx_shift  <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_ferr   <= 1'b0;
    end else begin
      r_rx_meta  <= RX;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (!r_rx_active) begin
        if (r_rx_prev && !r_rx_sync) begin
          r_rx_active <= 1'b1;
          r_rx_cnt    <= '0;
          r_rx_idx    <= 4'd0;
        end
      end else if (r_rx_idx == 4'd0) begin
        // Start bit checked at mid-bit; a line already back high was a glitch.
        if (r_rx_cnt == HALF_M1) begin
          r_rx_cnt <= '0;
          if (r_rx_sync) r_rx_active <= 1'b0;
          else           r_rx_idx    <= 4'd1;
        end else begin
          r_rx_cnt <= r_rx_cnt + 1'b1;
        end
      end else if (r_rx_cnt == DIV_M1) begin
        r_rx_cnt <= '0;
        if (r_rx_idx == 4'd9) begin
          r_rx_active <= 1'b0;
          if (r_rx_sync) r_rx_valid <= 1'b1;
          else           r_rx_ferr  <= 1'b1;
        end else begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_rx_idx   <= r_rx_idx + 4'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
    end
  end

  // ---------------- frame / bus state ----------------
  frame_t r_state, w_state_n;
  bus_t   r_bus, w_bus_n;
  logic   w_resp_nak;

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_acc;      // last three bytes, newest at the top
  logic [29:0] r_base;
  logic [15:0] r_n, r_wr_idx, r_ack_cnt;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-3:0] r_adr;

  logic        w_ferr, w_word_done, w_overrun, w_wr_req;
  logic        w_bus_ack, w_bus_err, w_last_ack, w_bus_abort, w_tx_start, w_tx_end;
  logic [15:0] w_count_n;
  logic [29:0] w_next_adr;

  // Framing errors during the response are ignored along with any other byte.
  assign w_ferr      = r_rx_ferr && (r_state != F_RESP);
  assign w_word_done = (r_state == F_DATA) && r_rx_valid && (r_byte_cnt == 2'd3) && (r_wr_idx != r_n);
  assign w_overrun   = w_word_done && (r_bus == B_WRITE);
  assign w_wr_req    = w_word_done && (r_bus == B_IDLE);
  assign w_bus_err   = (r_bus == B_WRITE) && err_i;
  assign w_bus_ack   = (r_bus == B_WRITE) && ack_i && !err_i;
  assign w_last_ack  = w_bus_ack && ((r_ack_cnt + 16'd1) == r_n);
  assign w_count_n   = {r_rx_shift, r_acc[23:16]};
  assign w_next_adr  = r_base + {14'd0, r_wr_idx};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= F_SYNC;
      r_bus   <= B_IDLE;
    end else begin
      r_state <= w_state_n;
      r_bus   <= w_bus_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_resp_nak = 1'b0;
    if (w_ferr && (r_state != F_SYNC)) begin
      w_state_n = F_SYNC;
    end else begin
      case (r_state)
        F_SYNC:  if (r_rx_valid && (r_rx_shift == 8'hA5)) w_state_n = F_ADDR;
        F_ADDR:  if (r_rx_valid && (r_byte_cnt == 2'd3)) w_state_n = F_COUNT;
        F_COUNT: if (r_rx_valid && (r_byte_cnt == 2'd1))
                   w_state_n = (w_count_n == 16'd0) ? F_RESP : F_DATA;
        F_DATA: begin
          if (w_bus_err || w_overrun) begin
            w_state_n  = F_RESP;
            w_resp_nak = 1'b1;
          end else if (w_last_ack) begin
            w_state_n = F_RESP;
          end
        end
        F_RESP:  if (w_tx_end) w_state_n = F_SYNC;
        default: w_state_n = F_SYNC;
      endcase
    end
  end

  // Leaving DATA for any reason (abort, framing error) kills an open bus cycle.
  assign w_bus_abort = (r_state == F_DATA) && (w_state_n != F_DATA);
  assign w_tx_start  = (r_state != F_RESP) && (w_state_n == F_RESP);

  always_comb begin
    w_bus_n = r_bus;
    case (r_bus)
      B_IDLE:  if (w_wr_req) w_bus_n = B_WRITE;
      B_WRITE: if (ack_i || err_i || w_bus_abort) w_bus_n = B_IDLE;
      default: w_bus_n = B_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_byte_cnt <= 2'd0;
      r_acc      <= 24'd0;
      r_base     <= 30'd0;
      r_n        <= 16'd0;
      r_wr_idx   <= 16'd0;
      r_ack_cnt  <= 16'd0;
      r_wdata    <= '0;
      r_adr      <= '0;
    end else if (w_ferr) begin
      r_byte_cnt <= 2'd0;
      r_wr_idx   <= 16'd0;
      r_ack_cnt  <= 16'd0;
    end else begin
      if (r_rx_valid) begin
        case (r_state)
          F_SYNC: begin
            r_byte_cnt <= 2'd0;
            r_wr_idx   <= 16'd0;
            r_ack_cnt  <= 16'd0;
          end
          F_ADDR: begin
            r_acc      <= {r_rx_shift, r_acc[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // Top two address bits are dropped: adr_o is a 30-bit word address.
            if (r_byte_cnt == 2'd3) r_base <= {r_rx_shift[5:0], r_acc};
          end
          F_COUNT: begin
            r_acc <= {r_rx_shift, r_acc[23:8]};
            if (r_byte_cnt == 2'd1) begin
              r_n        <= w_count_n;
              r_byte_cnt <= 2'd0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
          F_DATA: begin
            if (r_wr_idx != r_n) begin
              r_acc      <= {r_rx_shift, r_acc[23:8]};
              r_byte_cnt <= r_byte_cnt + 2'd1;
              if (w_wr_req) begin
                r_wdata  <= XLEN'({r_rx_shift, r_acc});
                r_adr    <= (XLEN-2)'(w_next_adr);
                r_wr_idx <= r_wr_idx + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
      if (w_bus_ack && (r_state == F_DATA)) r_ack_cnt <= r_ack_cnt + 16'd1;
    end
  end

  // ---------------- transmitter ----------------
  logic          r_tx_active;
  logic [9:0]    r_tx_shift;  // {stop, data, start}, shifted out from bit 0
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_idx;
  logic          r_done;

  assign w_tx_end = r_tx_active && (r_tx_cnt == DIV_M1) && (r_tx_idx == 4'd9);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tx_active <= 1'b0;
      r_tx_shift  <= 10'h3FF;
      r_tx_cnt    <= '0;
      r_tx_idx    <= 4'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_tx_end;
      if (w_tx_start) begin
        r_tx_active <= 1'b1;
        r_tx_shift  <= {1'b1, (w_resp_nak ? 8'h15 : 8'h06), 1'b0};
        r_tx_cnt    <= '0;
        r_tx_idx    <= 4'd0;
      end else if (r_tx_active) begin
        if (r_tx_cnt == DIV_M1) begin
          r_tx_cnt   <= '0;
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
          r_tx_idx   <= r_tx_idx + 4'd1;
          if (r_tx_idx == 4'd9) r_tx_active <= 1'b0;
        end else begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign TX           = r_tx_active ? r_tx_shift[0] : 1'b1;
  assign cyc_o        = (r_bus == B_WRITE);
  assign stb_o        = (r_bus == B_WRITE);
  assign we_o         = (r_bus == B_WRITE);
  assign sel_o        = {4{r_bus == B_WRITE}};
  assign adr_o        = r_adr;
  assign master_dat_o = r_wdata;
  assign busy_o       = (r_state != F_SYNC);
  assign done_o       = r_done;

endmodule
